// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target with 7-bit address match, register pointer and byte register file
// Ports: clk, rst (async, active-high); i_scl/i_sda bus inputs, o_sda_oe open-drain pull-low enable;
//        i_reg_we/i_reg_waddr/i_reg_wdata local register write; o_wr_valid/o_wr_addr/o_wr_data bus
//        write commit; o_busy addressed-transaction flag.
// Option: define I2C_SLV_AUTOINC_EN to advance the pointer after each written or master-ACKed read byte.
module i2c_slave_responder #(
    parameter logic [6:0] C_DEV_ADDR = 7'h50,
    parameter int         C_DEPTH    = 16,
    localparam int        PW         = $clog2(C_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_scl,
    input  logic          i_sda,
    output logic          o_sda_oe,
    input  logic          i_reg_we,
    input  logic [PW-1:0] i_reg_waddr,
    input  logic [7:0]    i_reg_wdata,
    output logic          o_wr_valid,
    output logic [PW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_data,
    output logic          o_busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t        state, state_n;
    logic [2:0]    scl_s, sda_s;
    logic          scl_rise, scl_fall, sda_rise, sda_fall;
    logic [7:0]    sh, sh_n;
    logic [3:0]    cnt, cnt_n;
    logic [PW-1:0] ptr, ptr_n, ptr_inc;
    logic          rd, rd_n, oe_n, busy_n, commit, load, last, match;
    logic [7:0]    regs [C_DEPTH];
    logic [7:0]    rbyte;

`ifdef I2C_SLV_AUTOINC_EN
    assign ptr_inc = ptr + 1'b1;
`else
    assign ptr_inc = ptr;
`endif

    assign rbyte = regs[ptr];
    assign last  = scl_fall && cnt == 4'd8;
    assign match = sh[7:1] == C_DEV_ADDR;

    // Edge pulses are registered, so scl_s[2]/sda_s[2] are the levels aligned with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s    <= 3'b111;
            sda_s    <= 3'b111;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            sda_rise <= 1'b0;
            sda_fall <= 1'b0;
        end else begin
            scl_s    <= {scl_s[1:0], i_scl};
            sda_s    <= {sda_s[1:0], i_sda};
            scl_rise <= scl_s[1] & ~scl_s[2];
            scl_fall <= ~scl_s[1] & scl_s[2];
            sda_rise <= sda_s[1] & ~sda_s[2];
            sda_fall <= ~sda_s[1] & sda_s[2];
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        ptr_n   = ptr;
        rd_n    = rd;
        oe_n    = o_sda_oe;
        busy_n  = o_busy;
        commit  = 1'b0;
        load    = 1'b0;
        if (scl_rise && (state == ADDR || state == PTR || state == WDATA)) begin
            sh_n  = {sh[6:0], sda_s[2]};
            cnt_n = cnt + 4'd1;
        end
        if (scl_rise && state == RDATA) cnt_n = cnt + 4'd1;
        case (state)
            ADDR: if (last) begin
                rd_n    = sh[0];
                oe_n    = match;
                busy_n  = o_busy | match;
                state_n = match ? ADDR_ACK : IGNORE;
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                cnt_n = 4'd0;
                if (state == ADDR_ACK && rd) begin
                    load = 1'b1;
                end else begin
                    oe_n    = 1'b0;
                    state_n = state == ADDR_ACK ? PTR : WDATA;
                end
            end
            PTR: if (last) begin
                ptr_n   = sh[PW-1:0];
                oe_n    = 1'b1;
                state_n = PTR_ACK;
            end
            WDATA: if (last) begin
                commit  = 1'b1;
                ptr_n   = ptr_inc;
                oe_n    = 1'b1;
                state_n = WDATA_ACK;
            end
            RDATA: if (scl_fall) begin
                if (cnt == 4'd8) begin
                    oe_n    = 1'b0;
                    state_n = RACK;
                end else begin
                    sh_n = {sh[6:0], 1'b0};
                    oe_n = ~sh[6];
                end
            end
            RACK: begin
                if (scl_rise) begin
                    state_n = sda_s[2] ? IGNORE : RACK;
                    ptr_n   = sda_s[2] ? ptr : ptr_inc;
                end
                if (scl_fall) load = 1'b1;
            end
            default: ;
        endcase
        if (load) begin
            sh_n    = rbyte;
            oe_n    = ~rbyte[7];
            cnt_n   = 4'd0;
            state_n = RDATA;
        end
        if (sda_fall && scl_s[2]) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
        end
        if (sda_rise && scl_s[2]) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sh         <= 8'h00;
            cnt        <= 4'd0;
            ptr        <= '0;
            rd         <= 1'b0;
            o_sda_oe   <= 1'b0;
            o_busy     <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= 8'h00;
        end else begin
            state      <= state_n;
            sh         <= sh_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            rd         <= rd_n;
            o_sda_oe   <= oe_n;
            o_busy     <= busy_n;
            o_wr_valid <= commit;
            if (commit) begin
                o_wr_addr <= ptr;
                o_wr_data <= sh;
            end
        end
    end

    // Bus commit is scheduled last so it wins a same-address collision with a local write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_DEPTH; i++) regs[i] <= 8'h00;
        end else begin
            if (i_reg_we) regs[i_reg_waddr] <= i_reg_wdata;
            if (commit) regs[ptr] <= sh;
        end
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bus-master driven check of i2c_slave_responder against a register-file model
module tb_i2c_slave_responder;
    localparam int Q = 5;
`ifdef I2C_SLV_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1, i_reg_we = 1'b0;
    logic [3:0] i_reg_waddr = 4'd0;
    logic [7:0] i_reg_wdata = 8'h00;
    logic       o_sda_oe, o_wr_valid, o_busy, sda_bus;
    logic [3:0] o_wr_addr;
    logic [7:0] o_wr_data;
    int         total = 0, bad = 0, mptr = 0;
    logic [7:0] mem [16];
    logic [7:0] wbuf [4];
    logic [11:0] wq [$];
    logic [11:0] eq [$];

    typedef struct { int op; logic [7:0] dev, ptr, dat, rd; logic ack; } vec_t;
    vec_t tbl [8];

    assign sda_bus = m_sda & ~o_sda_oe;
    always #10 clk = ~clk;

    i2c_slave_responder dut (
        .clk(clk), .rst(rst), .i_scl(m_scl), .i_sda(sda_bus), .o_sda_oe(o_sda_oe),
        .i_reg_we(i_reg_we), .i_reg_waddr(i_reg_waddr), .i_reg_wdata(i_reg_wdata),
        .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_busy(o_busy)
    );

    always @(negedge clk) if (o_wr_valid) wq.push_back({o_wr_addr, o_wr_data});

    function automatic int inc(int p);
        return (p + int'(AUTO)) % 16;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic wait_q;
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start;
        wait_q; m_sda = 1'b0; wait_q; m_scl = 1'b0;
    endtask

    task automatic i2c_rstart;
        wait_q; m_sda = 1'b1; wait_q; m_scl = 1'b1; wait_q; m_sda = 1'b0; wait_q; m_scl = 1'b0;
    endtask

    task automatic i2c_stop;
        wait_q; m_sda = 1'b0; wait_q; m_scl = 1'b1; wait_q; m_sda = 1'b1; wait_q; wait_q;
    endtask

    task automatic clk_bit(input logic b, output logic s);
        wait_q; m_sda = b; wait_q; m_scl = 1'b1; wait_q; s = sda_bus; wait_q; m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d, output logic s);
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~ack, s);
    endtask

    task automatic local_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        i_reg_we = 1'b1; i_reg_waddr = a; i_reg_wdata = d;
        @(negedge clk);
        i_reg_we = 1'b0;
        mem[a] = d;
    endtask

    task automatic check_commits;
        chk("commit_count", wq.size(), eq.size());
        while (wq.size() > 0 && eq.size() > 0) chk("commit", wq.pop_front(), eq.pop_front());
        wq.delete();
        eq.delete();
    endtask

    task automatic bus_write(input logic [7:0] dev, input logic [7:0] p, input int n, input logic ok);
        logic a;
        i2c_start;
        write_byte(dev, a);
        chk("w_dev_ack", a, ok);
        chk("busy", o_busy, ok);
        write_byte(p, a);
        chk("w_ptr_ack", a, ok);
        if (ok) mptr = int'(p[3:0]);
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], a);
            chk("w_data_ack", a, ok);
            if (ok) begin
                eq.push_back({4'(mptr), wbuf[i]});
                mem[mptr] = wbuf[i];
                mptr = inc(mptr);
            end
        end
        i2c_stop;
        chk("w_busy_off", o_busy, 0);
        check_commits;
    endtask

    task automatic bus_read(input logic [7:0] p, input bit setp, input int n, output logic [7:0] first);
        logic a, s;
        logic [7:0] d;
        first = 8'h00;
        i2c_start;
        if (setp) begin
            write_byte(8'hA0, a);
            chk("r_wdev_ack", a, 1);
            write_byte(p, a);
            chk("r_ptr_ack", a, 1);
            mptr = int'(p[3:0]);
            i2c_rstart;
        end
        write_byte(8'hA1, a);
        chk("r_dev_ack", a, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, d, s);
            chk("rd_data", d, mem[mptr]);
            if (i == 0) first = d;
            if (i < n - 1) mptr = inc(mptr);
            else chk("rack_release", s, 1);
        end
        i2c_stop;
        chk("r_busy_off", o_busy, 0);
        check_commits;
    endtask

    initial begin
        logic [7:0] f;
        logic a, s;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        tbl[0] = '{0, 8'hA0, 8'h03, 8'h5A, 8'h00, 1'b1};
        tbl[1] = '{1, 8'hA0, 8'h03, 8'h00, 8'h5A, 1'b1};
        tbl[2] = '{2, 8'h00, 8'h03, 8'hC6, 8'h00, 1'b1};
        tbl[3] = '{1, 8'hA0, 8'h03, 8'h00, 8'hC6, 1'b1};
        tbl[4] = '{0, 8'hA2, 8'h00, 8'h77, 8'h00, 1'b0};
        tbl[5] = '{1, 8'hA0, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[6] = '{0, 8'hA0, 8'h25, 8'h99, 8'h00, 1'b1};
        tbl[7] = '{1, 8'hA0, 8'h05, 8'h00, 8'h99, 1'b1};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_oe", o_sda_oe, 0);
        chk("rst_wr_valid", o_wr_valid, 0);
        chk("rst_wr_addr", o_wr_addr, 0);
        chk("rst_wr_data", o_wr_data, 0);
        chk("rst_busy", o_busy, 0);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].op == 0) begin
                wbuf[0] = tbl[i].dat;
                bus_write(tbl[i].dev, tbl[i].ptr, 1, tbl[i].ack);
            end else if (tbl[i].op == 1) begin
                bus_read(tbl[i].ptr, 1'b1, 1, f);
                chk("tbl_rd", f, tbl[i].rd);
            end else begin
                local_write(tbl[i].ptr[3:0], tbl[i].dat);
            end
        end

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        bus_write(8'hA0, 8'h0F, 2, 1'b1);
        bus_read(8'h0F, 1'b1, 1, f);
        chk("wrap_r15", f, AUTO ? 8'h11 : 8'h22);
        bus_read(8'h00, 1'b1, 1, f);
        chk("wrap_r0", f, AUTO ? 8'h22 : 8'h00);
        bus_read(8'h0E, 1'b1, 3, f);

        i2c_start;
        write_byte(8'hA0, a);
        write_byte(8'h02, a);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
        i2c_stop;
        chk("abort_busy", o_busy, 0);
        check_commits;
        wbuf[0] = 8'h3C;
        bus_write(8'hA0, 8'h02, 1, 1'b1);
        bus_read(8'h02, 1'b1, 1, f);
        chk("abort_then_write", f, 8'h3C);

        local_write(4'd7, 8'h0F);
        i2c_start;
        write_byte(8'hA0, a);
        write_byte(8'h07, a);
        i2c_rstart;
        write_byte(8'hA1, a);
        wait_q;
        chk("rdata_drive0", o_sda_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_oe", o_sda_oe, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_wr_valid", o_wr_valid, 0);
        chk("mid_rst_wr_addr", o_wr_addr, 0);
        chk("mid_rst_wr_data", o_wr_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mptr = 0;
        wq.delete();
        i2c_stop;
        bus_read(8'h00, 1'b0, 1, f);
        bus_read(8'h07, 1'b1, 1, f);
        chk("rst_reg7", f, 8'h00);
        bus_read(8'h03, 1'b1, 1, f);
        chk("rst_reg3", f, 8'h00);

        for (int it = 0; it < 24; it++) begin
            int op, n;
            op = $urandom_range(0, 4);
            n  = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            case (op)
                0: bus_write(8'hA0, 8'($urandom), n, 1'b1);
                1: bus_read(8'($urandom), 1'b1, n, f);
                2: bus_read(8'h00, 1'b0, n, f);
                3: local_write(4'($urandom), 8'($urandom));
                default: bus_write({C_MIS(), 1'b0}, 8'($urandom), 1, 1'b0);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [6:0] C_MIS();
        return 7'h50 ^ 7'($urandom_range(1, 127));
    endfunction
endmodule
